// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue stage in front of the 145-bit GF(2^m) polynomial ALU.
// Accepts one instruction at a time, strobes the ALU, waits for compute_done,
// and returns both result words on a valid/ready response port. The modulus
// is cached so the ALU modulus register is reloaded only when it changes.
// Optional WAIT watchdog: define ALU_ISSUE_TIMEOUT_EN.
module alu_issue_ctrl #(
  parameter int unsigned DAT_W   = 144,
  parameter int unsigned LDAT_W  = 145,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [3:0]        req_op,
  input  logic [LDAT_W-1:0] req_o_dat,
  input  logic [DAT_W-1:0]  req_t_dat,
  input  logic [LDAT_W-1:0] req_mod_dat,
  output logic [3:0]        alu_typ_sel,
  output logic              alu_o_sel,
  output logic              alu_t_sel,
  output logic              alu_mod_sel,
  output logic [LDAT_W-1:0] alu_o_dat,
  output logic [DAT_W-1:0]  alu_t_dat,
  output logic [LDAT_W-1:0] alu_mod_dat,
  input  logic [DAT_W-1:0]  alu_r_dat1,
  input  logic [DAT_W-1:0]  alu_r_dat2,
  input  logic              compute_done,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [DAT_W-1:0]  rsp_dat1,
  output logic [DAT_W-1:0]  rsp_dat2,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                req_rdy_q, req_rdy_d;
  logic [3:0]          alu_typ_sel_q, alu_typ_sel_d;
  logic                alu_o_sel_q, alu_o_sel_d;
  logic                alu_t_sel_q, alu_t_sel_d;
  logic                alu_mod_sel_q, alu_mod_sel_d;
  logic [LDAT_W-1:0]   alu_o_dat_q, alu_o_dat_d;
  logic [DAT_W-1:0]    alu_t_dat_q, alu_t_dat_d;
  logic [LDAT_W-1:0]   alu_mod_dat_q, alu_mod_dat_d;
  logic                mod_cache_vld_q, mod_cache_vld_d;
  logic                wait_first_q, wait_first_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic [DAT_W-1:0]    rsp_dat1_q, rsp_dat1_d;
  logic [DAT_W-1:0]    rsp_dat2_q, rsp_dat2_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic                op_legal;
  logic                op_mod;
  logic                timeout;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  // TIMEOUT has no effect without the watchdog
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout        = 1'b0;
`endif

  // Opcode decode: legal set and the ops that consume the modulus
  always_comb begin
    op_legal = 1'b0;
    op_mod   = 1'b0;
    case (req_op)
      4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111: op_legal = 1'b1;
      4'b0011, 4'b1000, 4'b1001: begin
        op_legal = 1'b1;
        op_mod   = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    alu_typ_sel_d   = alu_typ_sel_q;
    alu_o_sel_d     = 1'b0;
    alu_t_sel_d     = 1'b0;
    alu_mod_sel_d   = 1'b0;
    alu_o_dat_d     = alu_o_dat_q;
    alu_t_dat_d     = alu_t_dat_q;
    alu_mod_dat_d   = alu_mod_dat_q;
    mod_cache_vld_d = mod_cache_vld_q;
    rsp_dat1_d      = rsp_dat1_q;
    rsp_dat2_d      = rsp_dat2_q;
    rsp_err_d       = rsp_err_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
    wait_cnt_d      = (state_q == WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
`endif
    case (state_q)
      IDLE: begin
        if (req_vld && req_rdy_q) begin
          if (op_legal) begin
            state_d       = ISSUE;
            alu_typ_sel_d = req_op;
            alu_o_dat_d   = req_o_dat;
            alu_t_dat_d   = req_t_dat;
            alu_o_sel_d   = 1'b1;
            alu_t_sel_d   = 1'b1;
            if (op_mod && (!mod_cache_vld_q || (req_mod_dat != alu_mod_dat_q))) begin
              alu_mod_sel_d   = 1'b1;
              alu_mod_dat_d   = req_mod_dat;
              mod_cache_vld_d = 1'b1;
            end
          end else begin
            state_d    = RESP;
            rsp_err_d  = 1'b1;
            rsp_dat1_d = '0;
            rsp_dat2_d = '0;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // The first WAIT cycle blanks a done left over from the previous op
        if (compute_done && !wait_first_q) begin
          state_d    = RESP;
          rsp_dat1_d = alu_r_dat1;
          rsp_dat2_d = alu_r_dat2;
          rsp_err_d  = 1'b0;
        end else if (timeout) begin
          state_d         = RESP;
          rsp_dat1_d      = '0;
          rsp_dat2_d      = '0;
          rsp_err_d       = 1'b1;
          mod_cache_vld_d = 1'b0;
        end
      end
      RESP: if (rsp_rdy) state_d = IDLE;
    endcase
    wait_first_d = (state_d == WAIT) && (state_q != WAIT);
    req_rdy_d    = (state_d == IDLE);
    rsp_vld_d    = (state_d == RESP);
    busy_d       = (state_d != IDLE);
  end

  // State and output registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      req_rdy_q       <= 1'b0;
      alu_typ_sel_q   <= '0;
      alu_o_sel_q     <= 1'b0;
      alu_t_sel_q     <= 1'b0;
      alu_mod_sel_q   <= 1'b0;
      alu_o_dat_q     <= '0;
      alu_t_dat_q     <= '0;
      alu_mod_dat_q   <= '0;
      mod_cache_vld_q <= 1'b0;
      wait_first_q    <= 1'b0;
      rsp_vld_q       <= 1'b0;
      rsp_dat1_q      <= '0;
      rsp_dat2_q      <= '0;
      rsp_err_q       <= 1'b0;
      busy_q          <= 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      wait_cnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      req_rdy_q       <= req_rdy_d;
      alu_typ_sel_q   <= alu_typ_sel_d;
      alu_o_sel_q     <= alu_o_sel_d;
      alu_t_sel_q     <= alu_t_sel_d;
      alu_mod_sel_q   <= alu_mod_sel_d;
      alu_o_dat_q     <= alu_o_dat_d;
      alu_t_dat_q     <= alu_t_dat_d;
      alu_mod_dat_q   <= alu_mod_dat_d;
      mod_cache_vld_q <= mod_cache_vld_d;
      wait_first_q    <= wait_first_d;
      rsp_vld_q       <= rsp_vld_d;
      rsp_dat1_q      <= rsp_dat1_d;
      rsp_dat2_q      <= rsp_dat2_d;
      rsp_err_q       <= rsp_err_d;
      busy_q          <= busy_d;
`ifdef ALU_ISSUE_TIMEOUT_EN
      wait_cnt_q      <= wait_cnt_d;
`endif
    end
  end

  assign req_rdy     = req_rdy_q;
  assign alu_typ_sel = alu_typ_sel_q;
  assign alu_o_sel   = alu_o_sel_q;
  assign alu_t_sel   = alu_t_sel_q;
  assign alu_mod_sel = alu_mod_sel_q;
  assign alu_o_dat   = alu_o_dat_q;
  assign alu_t_dat   = alu_t_dat_q;
  assign alu_mod_dat = alu_mod_dat_q;
  assign rsp_vld     = rsp_vld_q;
  assign rsp_dat1    = rsp_dat1_q;
  assign rsp_dat2    = rsp_dat2_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;

endmodule
